// File: rtl/fifo_axis_reader.sv
// Read-side drain engine for the Ethernet CDC FIFO: pops FIFO words and
// presents them as an AXI-Stream master, with a 2-entry skid buffer that
// hides the 1-cycle BRAM read latency, plus per-frame beat tracking.
module fifo_axis_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH:0]   fifo_rd_data,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  frame_done,
    output logic [CNT_WIDTH-1:0]  beat_cnt,
    output logic                  in_frame
);

    // Buffer entries hold {tlast, data}; r_head is what the stream shows.
    logic [DATA_WIDTH:0]  r_head;
    logic [DATA_WIDTH:0]  r_tail;
    logic [1:0]           r_count;
    logic                 r_inflight;
    logic                 r_frameDone;
    logic [CNT_WIDTH-1:0] r_beatCnt;
    logic                 r_inFrame;

    logic                 w_pop;
    logic                 w_capture;
    logic [2:0]           w_nextCount;

    // Handshake, next occupancy and pop request; occupancy projection
    // includes the in-flight word so the buffer can never overflow.
    always_comb begin
        w_pop       = (r_count != 2'd0) & m_axis_tready;
        w_capture   = r_inflight;
        w_nextCount = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
        fifo_rd_en  = reset_n & ~fifo_empty & (w_nextCount < 3'd2);
    end

    // Two-entry FIFO-ordered buffer; the in-flight word is captured in the
    // cycle it arrives and is never re-sampled afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= 2'd0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= fifo_rd_en;
            r_count    <= w_nextCount[1:0];
            case ({w_capture, w_pop})
                2'b01: begin
                    r_head <= r_tail;
                end
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head <= fifo_rd_data;
                    end else begin
                        r_tail <= fifo_rd_data;
                    end
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_head <= fifo_rd_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= fifo_rd_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Frame tracking updates only on accepted beats; the counter saturates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frameDone <= 1'b0;
            r_beatCnt   <= '0;
            r_inFrame   <= 1'b0;
        end else begin
            r_frameDone <= 1'b0;
            if (w_pop) begin
                if (r_head[DATA_WIDTH]) begin
                    r_frameDone <= 1'b1;
                    r_beatCnt   <= '0;
                    r_inFrame   <= 1'b0;
                end else begin
                    if (r_beatCnt != {CNT_WIDTH{1'b1}}) begin
                        r_beatCnt <= r_beatCnt + CNT_WIDTH'(1);
                    end
                    r_inFrame <= 1'b1;
                end
            end
        end
    end

    // Stream outputs come straight from registers, so tvalid/tdata never
    // depend combinationally on tready.
    always_comb begin
        m_axis_tvalid = (r_count != 2'd0);
        m_axis_tdata  = r_head[DATA_WIDTH-1:0];
        m_axis_tlast  = r_head[DATA_WIDTH];
        frame_done    = r_frameDone;
        beat_cnt      = r_beatCnt;
        in_frame      = r_inFrame;
    end

endmodule
